// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered W-bit adder among N requesters.
// Optional signed-overflow output enabled by defining ADD_ARBITER_OVF_EN.
module add_arbiter #(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   in0_bus,
    input  logic [N*W-1:0]   in1_bus,
    output logic [N-1:0]     gnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDW-1:0]   out_id,
    output logic [W-1:0]     out_data,
`ifdef ADD_ARBITER_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t         state_q;
    logic [IDW-1:0] ptr_q;
    logic [W-1:0]   opa_q;
    logic [W-1:0]   opb_q;
    logic [N-1:0]   gnt_q;
    logic           valid_q;
    logic [IDW-1:0] id_q;
    logic [W-1:0]   data_q;

    logic [W-1:0]   in0_arr [N];
    logic [W-1:0]   in1_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign in0_arr[gi] = in0_bus[gi*W +: W];
        assign in1_arr[gi] = in1_bus[gi*W +: W];
    end

    // Search req starting at ptr_q and wrapping; first hit wins.
    logic           win_found_d;
    logic [IDW-1:0] win_idx_d;
    logic [IDW:0]   scan_idx;
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(N)) begin
                scan_idx = scan_idx - (IDW+1)'(N);
            end
            if (!win_found_d && req[scan_idx[IDW-1:0]]) begin
                win_found_d = 1'b1;
                win_idx_d   = scan_idx[IDW-1:0];
            end
        end
    end

    logic [IDW-1:0] ptr_d;
    logic [N-1:0]   gnt_d;
    logic [W-1:0]   sum_d;
    assign ptr_d = (win_idx_d == IDW'(N-1)) ? '0 : win_idx_d + 1'b1;
    assign gnt_d = N'(1) << win_idx_d;
    assign sum_d = opa_q + opb_q;

`ifdef ADD_ARBITER_OVF_EN
    logic ovf_q;
    logic ovf_d;
    assign ovf_d = (opa_q[W-1] == opb_q[W-1]) && (sum_d[W-1] != opa_q[W-1]);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
`ifdef ADD_ARBITER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        opa_q   <= in0_arr[win_idx_d];
                        opb_q   <= in1_arr[win_idx_d];
                        id_q    <= win_idx_d;
                        gnt_q   <= gnt_d;
                        ptr_q   <= ptr_d;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    gnt_q   <= '0;
                    data_q  <= sum_d;
`ifdef ADD_ARBITER_OVF_EN
                    ovf_q   <= ovf_d;
`endif
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = valid_q;
    assign out_id    = id_q;
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);
`ifdef ADD_ARBITER_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: stimulus queues expected grants/results,
// a negedge monitor pops and compares them.
module tb_add_arbiter;

    localparam int W = 32;
    localparam int N = 4;
    localparam int IDW = 2;

    logic             clk;
    logic             rstn;
    logic [N-1:0]     req;
    logic [N*W-1:0]   in0_bus;
    logic [N*W-1:0]   in1_bus;
    logic [N-1:0]     gnt;
    logic             out_valid;
    logic             out_ready;
    logic [IDW-1:0]   out_id;
    logic [W-1:0]     out_data;
    logic             busy;
`ifdef ADD_ARBITER_OVF_EN
    logic             out_ovf;
`endif

    add_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .in0_bus   (in0_bus),
        .in1_bus   (in1_bus),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
`ifdef ADD_ARBITER_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           ovf;
    } res_t;

    res_t           rq[$];
    logic [N-1:0]   gq[$];
    int             n_cmp = 0;
    int             n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic [N-1:0] g, input logic [IDW-1:0] id,
                            input logic [W-1:0] data, input logic ovf);
        res_t r;
        r.id = id;
        r.data = data;
        r.ovf = ovf;
        gq.push_back(g);
        rq.push_back(r);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        in0_bus[i*W +: W] = a;
        in1_bus[i*W +: W] = b;
    endtask

    task automatic issue(input logic [N-1:0] m);
        req = m;
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    // Monitor: every grant pulse and every accepted result is matched to the queues.
    always @(negedge clk) begin
        if (rstn) begin
            if (gnt != '0) begin
                if (gq.size() == 0) begin
                    check("gnt_unexpected", 64'(gnt), 64'd0);
                end else begin
                    logic [N-1:0] eg;
                    eg = gq.pop_front();
                    $display("grant gnt=%b", gnt);
                    check("gnt", 64'(gnt), 64'(eg));
                end
            end
            if (out_valid && out_ready) begin
                if (rq.size() == 0) begin
                    check("result_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    res_t er;
                    er = rq.pop_front();
                    $display("result id=%0d data=0x%08h", out_id, out_data);
                    check("out_id", 64'(out_id), 64'(er.id));
                    check("out_data", 64'(out_data), 64'(er.data));
`ifdef ADD_ARBITER_OVF_EN
                    check("out_ovf", 64'(out_ovf), 64'(er.ovf));
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        req = '0;
        in0_bus = '0;
        in1_bus = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_id", 64'(out_id), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single requester 1: 5 + 7, three cycles to idle.
        set_ops(1, 32'h0000_0005, 32'h0000_0007);
        push_txn(4'b0010, 2'd1, 32'h0000_000C, 1'b0);
        issue(4'b0010);
        check("t1_busy_calc", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("t1_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        check("t1_busy_done", 64'(busy), 64'd0);

        // ptr=2, only requester 0 active: skips 2,3 and wraps; also 0xFFFFFFFF+1.
        set_ops(0, 32'hFFFF_FFFF, 32'h0000_0001);
        push_txn(4'b0001, 2'd0, 32'h0000_0000, 1'b0);
        issue(4'b0001);
        wait_idle("t2_idle");
        // ptr now 1, so requester 1 beats requester 0.
        push_txn(4'b0010, 2'd1, 32'h0000_000C, 1'b0);
        issue(4'b0011);
        wait_idle("t3_idle");
        // Winner 3 wraps ptr to 0.
        set_ops(3, 32'hDEAD_BEEF, 32'h0000_0001);
        push_txn(4'b1000, 2'd3, 32'hDEAD_BEF0, 1'b0);
        issue(4'b1000);
        wait_idle("t4_idle");

        // Round robin with all four requesting: 0,1,2,3,0.
        set_ops(0, 32'h1111_1111, 32'h2222_2222);
        set_ops(2, 32'h1234_5678, 32'h1111_1111);
        push_txn(4'b0001, 2'd0, 32'h3333_3333, 1'b0);
        push_txn(4'b0010, 2'd1, 32'h0000_000C, 1'b0);
        push_txn(4'b0100, 2'd2, 32'h2345_6789, 1'b0);
        push_txn(4'b1000, 2'd3, 32'hDEAD_BEF0, 1'b0);
        push_txn(4'b0001, 2'd0, 32'h3333_3333, 1'b0);
        req = 4'b1111;
        repeat (13) @(posedge clk);
        #1;
        req = '0;
        wait_idle("rr_idle");

        // Backpressure: ptr=1, requester 2 wins, result held while req=1000 waits.
        out_ready = 1'b0;
        push_txn(4'b0100, 2'd2, 32'h2345_6789, 1'b0);
        push_txn(4'b1000, 2'd3, 32'hDEAD_BEF0, 1'b0);
        req = 4'b0100;
        @(posedge clk); #1;
        req = 4'b1000;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_id", 64'(out_id), 64'd2);
            check("bp_data", 64'(out_data), 64'h2345_6789);
            check("bp_no_gnt", 64'(gnt), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        req = '0;
        wait_idle("bp_idle");

        // Reset during CALC: ptr=0 here, requester 1 granted then reset.
        req = 4'b0010;
        @(posedge clk); #1;
        req = '0;
        check("mid_gnt", 64'(gnt), 64'b0010);
        check("mid_busy", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_gnt", 64'(gnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        check("mid_no_regrant", 64'(gnt), 64'd0);
        rstn = 1'b1;
        // ptr restarted at 0: requester 1 beats 2; 0x7FFFFFFF+1 overflows.
        set_ops(1, 32'h7FFF_FFFF, 32'h0000_0001);
        push_txn(4'b0010, 2'd1, 32'h8000_0000, 1'b1);
        issue(4'b0110);
        wait_idle("post_rst_idle");

        @(posedge clk); #1;
        check("gq_drained", 64'(gq.size()), 64'd0);
        check("rq_drained", 64'(rq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
